// File: rtl/apb_mem_bridge_if.sv
// Bus bundle between the MEM stage, the APB completer and the bridge.
// master: bridge view; slave: environment view.
interface apb_mem_bridge_if;
  logic        IsPerM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        proc_ready;
  logic [31:0] PerRdataM;
  logic        per_err;

  modport master (
    input  IsPerM, MemWriteM,
    input  ALUResultM, WriteDataM,
    input  PRDATA, PREADY, PSLVERR,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA,
    output proc_ready, PerRdataM,
    output per_err
  );

  modport slave (
    output IsPerM, MemWriteM,
    output ALUResultM, WriteDataM,
    output PRDATA, PREADY, PSLVERR,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    input  proc_ready, PerRdataM,
    input  per_err
  );
endinterface

// File: rtl/apb_mem_bridge.sv
// MEM-stage to APB bridge; optional ACCESS watchdog via APB_TIMEOUT_EN.
// Timeout forces completion with TIMEOUT_RDATA and sets per_err.
module apb_mem_bridge #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input logic             clk,
  input logic             rst,
  apb_mem_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;
  logic   timeoutHit;
  logic   isAccess;

  assign isAccess = (state == ACCESS);

`ifdef APB_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] toCnt;

  assign timeoutHit = isAccess && !bus.PREADY &&
                      (toCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt <= '0;
    end else if (isAccess && !bus.PREADY && !timeoutHit) begin
      toCnt <= toCnt + 1'b1;
    end else begin
      toCnt <= '0;
    end
  end
`else
  logic unusedCfg;

  assign timeoutHit = 1'b0;
  assign unusedCfg  = ^{TIMEOUT_RDATA, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (bus.IsPerM) stateNext = SETUP;
      SETUP:  stateNext = ACCESS;
      ACCESS: begin
        if (bus.PREADY || timeoutHit) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.PSEL       = 1'b0;
    bus.PENABLE    = 1'b0;
    bus.proc_ready = 1'b0;
    bus.PerRdataM  = 32'h0;
    unique case (state)
      IDLE: bus.proc_ready = 1'b1;
      SETUP: bus.PSEL = 1'b1;
      ACCESS: begin
        bus.PSEL       = 1'b1;
        bus.PENABLE    = 1'b1;
        bus.proc_ready = bus.PREADY | timeoutHit;
        if (!bus.PWRITE) begin
          bus.PerRdataM = timeoutHit ? TIMEOUT_RDATA
                                     : bus.PRDATA;
        end
      end
      default: bus.proc_ready = 1'b1;
    endcase
  end

  // Request fields are latched only on IDLE->SETUP and held to completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.PADDR  <= 32'h0;
      bus.PWDATA <= 32'h0;
      bus.PWRITE <= 1'b0;
    end else if (state == IDLE && bus.IsPerM) begin
      bus.PADDR  <= bus.ALUResultM;
      bus.PWDATA <= bus.WriteDataM;
      bus.PWRITE <= bus.MemWriteM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.per_err <= 1'b0;
    end else if (isAccess &&
                 ((bus.PREADY && bus.PSLVERR) || timeoutHit)) begin
      bus.per_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_apb_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errCnt = 0;
  int   chkCnt = 0;

  apb_mem_bridge_if bus ();

  apb_mem_bridge #(
`ifdef APB_TIMEOUT_EN
    .TIMEOUT_CYCLES(4),
`else
    .TIMEOUT_CYCLES(16),
`endif
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bus.IsPerM     = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.PRDATA     = 32'h0;
    bus.PREADY     = 1'b0;
    bus.PSLVERR    = 1'b0;
    step();
    step();
    rst = 1'b0;
    smp();
    chk("rst_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("rst_pen", {31'h0, bus.PENABLE}, 32'h0);
    chk("rst_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("rst_rdata", bus.PerRdataM, 32'h0);
    chk("rst_err", {31'h0, bus.per_err}, 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwrite", {31'h0, bus.PWRITE}, 32'h0);

    // write, zero wait states
    step();
    bus.IsPerM     = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.ALUResultM = 32'h4000_0010;
    bus.WriteDataM = 32'h1234_5678;
    bus.PREADY     = 1'b1;
    smp();
    chk("wr_n_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("wr_n_rdy", {31'h0, bus.proc_ready}, 32'h1);
    step();
    bus.IsPerM     = 1'b0;
    bus.ALUResultM = 32'h1111_1111;
    bus.WriteDataM = 32'h2222_2222;
    bus.MemWriteM  = 1'b0;
    smp();
    chk("wr_s_psel", {31'h0, bus.PSEL}, 32'h1);
    chk("wr_s_pen", {31'h0, bus.PENABLE}, 32'h0);
    chk("wr_s_rdy", {31'h0, bus.proc_ready}, 32'h0);
    chk("wr_s_paddr", bus.PADDR, 32'h4000_0010);
    chk("wr_s_pwdata", bus.PWDATA, 32'h1234_5678);
    chk("wr_s_pwrite", {31'h0, bus.PWRITE}, 32'h1);
    step();
    smp();
    chk("wr_a_pen", {31'h0, bus.PENABLE}, 32'h1);
    chk("wr_a_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("wr_a_pwrite", {31'h0, bus.PWRITE}, 32'h1);
    chk("wr_a_rdata", bus.PerRdataM, 32'h0);
    step();
    smp();
    chk("wr_i_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("wr_i_rdy", {31'h0, bus.proc_ready}, 32'h1);

    // read, three wait states, address input disturbed
    bus.IsPerM     = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = 32'h4000_0010;
    bus.PREADY     = 1'b0;
    bus.PRDATA     = 32'hCAFE_0001;
    step();
    bus.IsPerM = 1'b0;
    smp();
    chk("rd_s_psel", {31'h0, bus.PSEL}, 32'h1);
    step();
    bus.ALUResultM = 32'h9999_0000;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("rd_w%0d_rdy", i),
          {31'h0, bus.proc_ready}, 32'h0);
      chk($sformatf("rd_w%0d_pen", i),
          {31'h0, bus.PENABLE}, 32'h1);
      chk($sformatf("rd_w%0d_paddr", i),
          bus.PADDR, 32'h4000_0010);
      step();
    end
    bus.PREADY = 1'b1;
    smp();
    chk("rd_c_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("rd_c_rdata", bus.PerRdataM, 32'hCAFE_0001);
    chk("rd_c_paddr", bus.PADDR, 32'h4000_0010);
    step();

    // back-to-back write with slave error
    bus.IsPerM     = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.ALUResultM = 32'h4000_0020;
    bus.WriteDataM = 32'hA5A5_5A5A;
    bus.PSLVERR    = 1'b1;
    smp();
    chk("err_i_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("err_i_err", {31'h0, bus.per_err}, 32'h0);
    step();
    bus.IsPerM = 1'b0;
    smp();
    chk("b2b_s_psel", {31'h0, bus.PSEL}, 32'h1);
    chk("b2b_s_paddr", bus.PADDR, 32'h4000_0020);
    step();
    smp();
    chk("err_a_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("err_a_err", {31'h0, bus.per_err}, 32'h0);
    step();
    bus.PSLVERR = 1'b0;
    smp();
    chk("err_set", {31'h0, bus.per_err}, 32'h1);
    step();
    step();
    smp();
    chk("err_sticky", {31'h0, bus.per_err}, 32'h1);

    // reset during ACCESS
    bus.IsPerM     = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = 32'h4000_0030;
    bus.PREADY     = 1'b0;
    step();
    bus.IsPerM = 1'b0;
    step();
    smp();
    chk("mr_a_pen", {31'h0, bus.PENABLE}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    chk("mr_psel", {31'h0, bus.PSEL}, 32'h0);
    chk("mr_pen", {31'h0, bus.PENABLE}, 32'h0);
    chk("mr_err", {31'h0, bus.per_err}, 32'h0);
    chk("mr_paddr", bus.PADDR, 32'h0);
    chk("mr_rdy", {31'h0, bus.proc_ready}, 32'h1);

    // stuck completer
    bus.IsPerM     = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = 32'h4000_0040;
    bus.PRDATA     = 32'h0BAD_0BAD;
    step();
    bus.IsPerM = 1'b0;
    step();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("to_w%0d_rdy", i),
          {31'h0, bus.proc_ready}, 32'h0);
      step();
    end
    smp();
    chk("to_rdy", {31'h0, bus.proc_ready}, 32'h1);
    chk("to_rdata", bus.PerRdataM, 32'hDEAD_BEEF);
    chk("to_err_pre", {31'h0, bus.per_err}, 32'h0);
    step();
    smp();
    chk("to_err", {31'h0, bus.per_err}, 32'h1);
    chk("to_idle", {31'h0, bus.PSEL}, 32'h0);
`else
    repeat (20) step();
    smp();
    chk("stuck_rdy", {31'h0, bus.proc_ready}, 32'h0);
    chk("stuck_pen", {31'h0, bus.PENABLE}, 32'h1);
    chk("stuck_err", {31'h0, bus.per_err}, 32'h0);
    step();
    bus.PREADY = 1'b1;
    smp();
    chk("stuck_rdata", bus.PerRdataM, 32'h0BAD_0BAD);
    step();
    smp();
    chk("stuck_idle", {31'h0, bus.PSEL}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/apb_mem_bridge.md
APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before forced termination (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have parameter TIMEOUT_RDATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 Ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 IsPerM  in  1  MEM-stage instruction targets the peripheral space.
REQ-006 MemWriteM  in  1  MEM-stage access is a store (1) or load (0).
REQ-007 ALUResultM  in  32  MEM-stage byte address.
REQ-008 WriteDataM  in  32  MEM-stage store data.
REQ-009 PRDATA  in  32  APB read data.
REQ-010 PREADY  in  1  APB completer ready.
REQ-011 PSLVERR  in  1  APB completer error.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB control; PENABLE also feeds the hazard unit.
REQ-013 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-014 proc_ready  out  1  to hazard unit; peripheral access completes this cycle.
REQ-015 PerRdataM  out  32  load data to the MEM/WB register.
REQ-016 per_err  out  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS; state register only.
REQ-018 IDLE: PSEL=0, PENABLE=0, proc_ready=1; IsPerM=1 -> SETUP next edge; PADDR<=ALUResultM, PWDATA<=WriteDataM, PWRITE<=MemWriteM captured on that edge.
REQ-019 SETUP: PSEL=1, PENABLE=0, proc_ready=0; unconditionally -> ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1, proc_ready=PREADY (combinational); PREADY=1 -> IDLE; PREADY=0 -> remain in ACCESS.
REQ-021 PADDR/PWDATA/PWRITE SHALL hold constant from SETUP through the completing ACCESS cycle, regardless of input changes.
REQ-022 PerRdataM SHALL equal PRDATA in ACCESS when PWRITE=0, else 32'h0.
REQ-023 Minimum latency: IsPerM asserted in cycle N -> completion (PENABLE & proc_ready) in cycle N+2 with PREADY=1.
REQ-024 Back-to-back: IsPerM=1 in IDLE on the cycle after completion SHALL start a new SETUP; no idle gap beyond IDLE cycle.
REQ-025 PSLVERR=1 on a completing ACCESS cycle SHALL set per_err next edge; per_err cleared only by rst.
REQ-026 IsPerM dropping while in SETUP/ACCESS SHALL NOT abort the transfer.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, per_err=0, timeout counter=0; takes effect next edge, including mid-SETUP/ACCESS (transfer abandoned).
REQ-028 After reset: proc_ready=1, PerRdataM=0.

Configuration
REQ-029 Macro APB_TIMEOUT_EN: when defined, a counter increments each ACCESS cycle with PREADY=0; counter reaching TIMEOUT_CYCLES-1 with PREADY=0 SHALL force proc_ready=1, PerRdataM=TIMEOUT_RDATA (reads), set per_err, -> IDLE; counter clears on IDLE.
REQ-030 Without APB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-031 Write: IsPerM=1, MemWriteM=1, addr 32'h4000_0010, data 32'h1234_5678, PREADY=1 -> SETUP cycle N+1, ACCESS N+2 with PWRITE=1, proc_ready=1; IDLE N+3.
REQ-032 Read with 3 wait states: PREADY low 3 ACCESS cycles, PRDATA=32'hCAFE_0001 -> proc_ready=0 for 3 cycles, then proc_ready=1, PerRdataM=32'hCAFE_0001.
REQ-033 Input change: ALUResultM altered during ACCESS -> PADDR remains 32'h4000_0010 until completion.
REQ-034 Error: PSLVERR=1 with PREADY=1 -> per_err=1 next cycle, stays 1 until rst.
REQ-035 Reset mid-ACCESS: rst=1 -> next edge PSEL=0, PENABLE=0, state IDLE, per_err=0.
REQ-036 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 read -> 4th ACCESS cycle proc_ready=1, PerRdataM=32'hDEAD_BEEF, per_err=1 next edge.
